mem_slave_pipe: RTL and testbench

Parametrised single-port memory slave for the SoC bus: the next-generation replacement for the fixed 32-bit, single-cycle ROM/RAM slaves. It adds configurable data width, depth and read latency, an optional read-only mode, out-of-range and illegal-write error reporting, and a response buffer. The buffer keeps full throughput under `rsp_ready_i` backpressure without dropping data. It sits behind the bus interconnect, on the same valid/ready request/response channel as the existing slaves.

---
 rtl/mem_slave_pipe.sv | 147 ++++++++++++++
 tb/tb_mem_slave_pipe.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_slave_pipe.sv
// mem_slave_pipe: parametrised single-port memory slave.
// Requests are accepted on a valid/ready channel. Each request produces one
// response {err, data}. The response passes through LAT-1 pipeline stages
// into a response FIFO of depth LAT+1, so the slave never stalls a response
// it has already committed to, even under backpressure.
module mem_slave_pipe #(
    parameter int DP        = 4096,
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int LAT       = 1,
    parameter int READ_ONLY = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   data_i,
    input  logic [DW/8-1:0] sel_i,
    input  logic            we_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    output logic [DW-1:0]   data_o,
    output logic            rsp_err_o,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i
);

    localparam int NB = DW / 8;
    localparam int OB = (NB > 1) ? $clog2(NB) : 0;
    localparam int MW = (DP > 1) ? $clog2(DP) : 1;
    localparam int FD = LAT + 1;            // response FIFO depth
    localparam int PW = $clog2(FD);         // FIFO pointer width
    localparam int CW = $clog2(FD + 1);     // outstanding counter width
    localparam int EW = DW + 1;             // entry = {err, data}

    localparam logic [AW-1:0] DP_A     = AW'(DP);
    localparam logic [PW-1:0] PTR_LAST = PW'(FD - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(FD);

    logic [DW-1:0] mem [DP];
    logic [AW-1:0] word_idx;
    logic [DW-1:0] wmask;
    logic          in_range, accept, pop, mem_we;
    logic [EW-1:0] in_ent, push_ent, head;
    logic          push_vld;
    logic [CW-1:0] cnt, inflight, fifo_cnt;
    logic [EW-1:0] fifo [FD];
    logic [PW-1:0] wr_ptr, rd_ptr;

    // The full shifted address takes part in the range check, so an
    // aliasing high address is rejected as out of range, never wrapped.
    assign word_idx    = addr_i >> OB;
    assign in_range    = (word_idx < DP_A);
    assign req_ready_o = (cnt < CNT_MAX);
    assign accept      = req_valid_i && req_ready_o;
    assign mem_we      = accept && we_i && in_range && (READ_ONLY == 0);

    for (genvar b = 0; b < NB; b++) begin : g_mask
        assign wmask[b*8 +: 8] = {8{sel_i[b]}};
    end

    // Byte-masked write at the accept edge; storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[word_idx[MW-1:0]] <= (mem[word_idx[MW-1:0]] & ~wmask) | (data_i & wmask);
    end

    // Build the response for the request being accepted this cycle.
    always_comb begin
        in_ent = '0;
        if (!in_range || (we_i && READ_ONLY != 0))
            in_ent[DW] = 1'b1;
        else if (!we_i)
            in_ent[DW-1:0] = mem[word_idx[MW-1:0]];
    end

    if (LAT == 1) begin : g_direct
        assign push_vld = accept;
        assign push_ent = in_ent;
        assign inflight = '0;
    end else begin : g_pipe
        logic [LAT-2:0]         vld_pipe;
        logic [LAT-2:0][EW-1:0] ent_pipe;

        // Plain delay stages; LAT is at most 3, so there are one or two stages.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_pipe <= '0;
                ent_pipe <= '0;
            end else begin
                vld_pipe[0] <= accept;
                ent_pipe[0] <= in_ent;
                if (LAT == 3) begin
                    vld_pipe[LAT-2] <= vld_pipe[0];
                    ent_pipe[LAT-2] <= ent_pipe[0];
                end
            end
        end

        assign push_vld = vld_pipe[LAT-2];
        assign push_ent = ent_pipe[LAT-2];
        assign inflight = CW'($countones(vld_pipe));
    end

    // FIFO occupancy comes from the counters, since the pointers alone cannot
    // tell full from empty.
    assign fifo_cnt    = cnt - inflight;
    assign rsp_valid_o = (fifo_cnt != '0);
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign head        = fifo[rd_ptr];
    assign data_o      = rsp_valid_o ? head[DW-1:0] : '0;
    assign rsp_err_o   = rsp_valid_o && head[DW];

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // FIFO storage; contents are only visible while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push_vld)
            fifo[wr_ptr] <= push_ent;
    end

    // FIFO pointers wrap modulo the depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_vld) wr_ptr <= ptr_next(wr_ptr);
            if (pop)      rd_ptr <= ptr_next(rd_ptr);
        end
    end

    // Outstanding count: requests in the pipeline plus the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_slave_pipe.sv
// tb_mem_slave_pipe: four slaves with different configurations share one clock.
// A queue-based model predicts every response (value and arrival cycle), and
// one compare process checks all outputs each cycle. Directed sequences add
// hand-computed literal expectations.
module tb_mem_slave_pipe;

    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr      [NI];
    logic [31:0] data_in   [NI];
    logic [3:0]  sel       [NI];
    logic        we        [NI];
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic [31:0] data_out  [NI];
    logic        rsp_err   [NI];
    logic        rsp_valid [NI];
    logic        rsp_ready [NI];

    always #5 clk = ~clk;

    // Instance 0: LAT=2 DP=64; 1: LAT=3 DP=128; 2: LAT=1 DP=16; 3: LAT=1 DP=16 read-only.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_slave_pipe #(
            .DP       (g == 0 ? 64 : (g == 1 ? 128 : 16)),
            .DW       (32),
            .AW       (32),
            .LAT      (g == 0 ? 2 : (g == 1 ? 3 : 1)),
            .READ_ONLY(g == 3 ? 1 : 0)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .addr_i     (addr[g]),
            .data_i     (data_in[g]),
            .sel_i      (sel[g]),
            .we_i       (we[g]),
            .req_valid_i(req_valid[g]),
            .req_ready_o(req_ready[g]),
            .data_o     (data_out[g]),
            .rsp_err_o  (rsp_err[g]),
            .rsp_valid_o(rsp_valid[g]),
            .rsp_ready_i(rsp_ready[g])
        );
    end

    function automatic int lat_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 3 : 1);
    endfunction
    function automatic int dp_of(input int g);
        return (g == 0) ? 64 : ((g == 1) ? 128 : 16);
    endfunction
    function automatic bit ro_of(input int g);
        return (g == 3);
    endfunction

    typedef struct {
        logic [31:0] data;
        logic        err;
        bit          known;
        int          due;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } obs_t;

    exp_t        q    [NI][$];
    obs_t        logq [NI][$];
    logic [31:0] mdl  [NI][128];
    bit          kn   [NI][128];
    int          cyc     = 0;
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h, expected %h (cycle %0d)", nm, g, act, exp, cyc);
    endtask

    function automatic obs_t at(input int g, input int i);
        obs_t o;
        o.data = 32'hDEAD_BEEF;
        o.err  = 1'b1;
        if (i < logq[g].size()) o = logq[g][i];
        return o;
    endfunction

    // Compare process: check outputs mid-cycle, then apply this cycle's handshakes to the model.
    always @(negedge clk) begin
        bit          ev, inr;
        int          idx;
        exp_t        e;
        obs_t        o;
        logic [31:0] m;
        for (int g = 0; g < NI; g++) begin
            if (rst) begin
                q[g].delete();
                chk("rst_req_ready", g, 32'(req_ready[g]), 32'd1);
                chk("rst_rsp_valid", g, 32'(rsp_valid[g]), 32'd0);
                chk("rst_data",      g, data_out[g],       32'd0);
                chk("rst_err",       g, 32'(rsp_err[g]),   32'd0);
            end else begin
                ev = (q[g].size() > 0) && (q[g][0].due <= cyc);
                chk("rsp_valid", g, 32'(rsp_valid[g]), 32'(ev));
                chk("req_ready", g, 32'(req_ready[g]), 32'(q[g].size() < lat_of(g) + 1));
                if (rsp_valid[g] && ev) begin
                    chk("rsp_err", g, 32'(rsp_err[g]), 32'(q[g][0].err));
                    if (q[g][0].known) chk("rsp_data", g, data_out[g], q[g][0].data);
                end
                if (rsp_valid[g] && rsp_ready[g] && q[g].size() > 0) begin
                    o.data = data_out[g];
                    o.err  = rsp_err[g];
                    logq[g].push_back(o);
                    void'(q[g].pop_front());
                end
                if (req_valid[g] && req_ready[g]) begin
                    idx     = int'(addr[g] >> 2);
                    inr     = idx < dp_of(g);
                    e.due   = cyc + lat_of(g);
                    e.data  = 32'd0;
                    e.known = 1'b1;
                    if (we[g]) begin
                        e.err = !inr || ro_of(g);
                        if (inr && !ro_of(g)) begin
                            m = {{8{sel[g][3]}}, {8{sel[g][2]}}, {8{sel[g][1]}}, {8{sel[g][0]}}};
                            mdl[g][idx] = (mdl[g][idx] & ~m) | (data_in[g] & m);
                            if (sel[g] == 4'hF) kn[g][idx] = 1'b1;
                        end
                    end else begin
                        e.err = !inr;
                        if (inr) begin
                            e.data  = mdl[g][idx];
                            e.known = kn[g][idx];
                        end
                    end
                    q[g].push_back(e);
                end
            end
        end
        cyc++;
    end

    // Present one request and hold it until accepted (bounded).
    task automatic req(input int g, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit done = 1'b0;
        we[g] = w; addr[g] = a; data_in[g] = d; sel[g] = s; req_valid[g] = 1'b1;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            done = req_ready[g];
            @(posedge clk);
            #1;
        end
        req_valid[g] = 1'b0;
        chk("req_accept", g, 32'(done), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        obs_t        o;
        logic [31:0] old;
        int          t0, stale;
        for (int g = 0; g < NI; g++) begin
            addr[g] = '0; data_in[g] = '0; sel[g] = '0; we[g] = 1'b0;
            req_valid[g] = 1'b0; rsp_ready[g] = 1'b1;
            for (int i = 0; i < 128; i++) begin
                kn[g][i]  = 1'b0;
                mdl[g][i] = '0;
            end
        end

        // Reset values
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            chk("post_rst_ready", g, 32'(req_ready[g]), 32'd1);
            chk("post_rst_valid", g, 32'(rsp_valid[g]), 32'd0);
            chk("post_rst_data",  g, data_out[g],       32'd0);
            chk("post_rst_err",   g, 32'(rsp_err[g]),   32'd0);
        end
        @(posedge clk); #1;

        // Byte-masked write then read, LAT=2
        logq[0].delete();
        req(0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b1111);
        req(0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101);
        req(0, 1'b0, 32'h10, 32'h0, 4'b0000);
        idle(6);
        chk("bm_count", 0, 32'(logq[0].size()), 32'd3);
        o = at(0, 0); chk("bm_w1_data", 0, o.data, 32'h0); chk("bm_w1_err", 0, 32'(o.err), 32'd0);
        o = at(0, 1); chk("bm_w2_data", 0, o.data, 32'h0); chk("bm_w2_err", 0, 32'(o.err), 32'd0);
        o = at(0, 2); chk("bm_rd_data", 0, o.data, 32'hAA22_CC44); chk("bm_rd_err", 0, 32'(o.err), 32'd0);

        // Streaming, LAT=3: ramp write then 100 back-to-back reads
        for (int k = 0; k < 100; k++) req(1, 1'b1, 32'(k * 4), 32'h1000_0000 + 32'(k * 3), 4'hF);
        idle(5);
        logq[1].delete();
        t0 = cyc;
        for (int k = 0; k < 100; k++) req(1, 1'b0, 32'(k * 4), 32'h0, 4'h0);
        chk("stream_cycles", 1, 32'(cyc - t0), 32'd100);
        idle(6);
        chk("stream_count", 1, 32'(logq[1].size()), 32'd100);
        for (int k = 0; k < 100; k++) begin
            o = at(1, k);
            chk("stream_data", 1, o.data, 32'h1000_0000 + 32'(k * 3));
        end
        o = at(1, 99); chk("stream_last", 1, o.data, 32'h1000_0129);

        // Backpressure, LAT=1
        req(2, 1'b1, 32'h4, 32'hCAFE_0001, 4'hF);
        req(2, 1'b1, 32'h8, 32'hCAFE_0002, 4'hF);
        idle(3);
        logq[2].delete();
        rsp_ready[2] = 1'b0;
        req(2, 1'b0, 32'h4, 32'h0, 4'h0);
        req(2, 1'b0, 32'h8, 32'h0, 4'h0);
        we[2] = 1'b0; addr[2] = 32'h4; req_valid[2] = 1'b1;
        @(negedge clk);
        chk("bp_ready_low", 2, 32'(req_ready[2]), 32'd0);
        chk("bp_valid",     2, 32'(rsp_valid[2]), 32'd1);
        chk("bp_head",      2, data_out[2],       32'hCAFE_0001);
        repeat (2) @(negedge clk);
        chk("bp_stable",    2, data_out[2],       32'hCAFE_0001);
        chk("bp_ready_low2", 2, 32'(req_ready[2]), 32'd0);
        @(posedge clk); #1 rsp_ready[2] = 1'b1;
        @(posedge clk); #1 rsp_ready[2] = 1'b0;
        @(negedge clk);
        chk("bp_ready_back", 2, 32'(req_ready[2]), 32'd1);
        chk("bp_head2",      2, data_out[2],       32'hCAFE_0002);
        @(posedge clk); #1 req_valid[2] = 1'b0;
        rsp_ready[2] = 1'b1;
        idle(4);
        chk("bp_count", 2, 32'(logq[2].size()), 32'd3);
        o = at(2, 0); chk("bp_rsp0", 2, o.data, 32'hCAFE_0001);
        o = at(2, 1); chk("bp_rsp1", 2, o.data, 32'hCAFE_0002);
        o = at(2, 2); chk("bp_rsp2", 2, o.data, 32'hCAFE_0001);

        // Error cases, DP=16
        logq[2].delete();
        req(2, 1'b1, 32'h0,  32'h0102_0304, 4'hF);
        req(2, 1'b1, 32'h3C, 32'h5A5A_5A5A, 4'hF);
        req(2, 1'b0, 32'h3C, 32'h0, 4'h0);
        req(2, 1'b0, 32'h40, 32'h0, 4'h0);
        req(2, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF);
        req(2, 1'b0, 32'h0,  32'h0, 4'h0);
        idle(3);
        o = at(2, 2); chk("err_last_word", 2, o.data, 32'h5A5A_5A5A); chk("err_last_word_e", 2, 32'(o.err), 32'd0);
        o = at(2, 3); chk("err_oor_rd_data", 2, o.data, 32'h0); chk("err_oor_rd_e", 2, 32'(o.err), 32'd1);
        o = at(2, 4); chk("err_oor_wr_data", 2, o.data, 32'h0); chk("err_oor_wr_e", 2, 32'(o.err), 32'd1);
        o = at(2, 5); chk("err_no_alias", 2, o.data, 32'h0102_0304);

        // Read-only: rejected write leaves the old word in place
        logq[3].delete();
        req(3, 1'b0, 32'h0, 32'h0, 4'h0);
        idle(3);
        o = at(3, 0); old = o.data;
        chk("ro_rd0_err", 3, 32'(o.err), 32'd0);
        req(3, 1'b1, 32'h0, ~old, 4'hF);
        req(3, 1'b0, 32'h0, 32'h0, 4'h0);
        idle(3);
        o = at(3, 1); chk("ro_wr_err", 3, 32'(o.err), 32'd1); chk("ro_wr_data", 3, o.data, 32'h0);
        o = at(3, 2); chk("ro_rd_old", 3, o.data, old); chk("ro_rd_err", 3, 32'(o.err), 32'd0);

        // Reset with three responses outstanding
        logq[1].delete();
        rsp_ready[1] = 1'b0;
        req(1, 1'b0, 32'h0, 32'h0, 4'h0);
        req(1, 1'b0, 32'h4, 32'h0, 4'h0);
        req(1, 1'b0, 32'h8, 32'h0, 4'h0);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rsp_ready[1] = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid[1]) stale++;
        end
        chk("mr_no_stale", 1, 32'(stale), 32'd0);
        chk("mr_log_empty", 1, 32'(logq[1].size()), 32'd0);
        @(posedge clk); #1;
        req(1, 1'b0, 32'h14, 32'h0, 4'h0);
        idle(5);
        o = at(1, 0); chk("mr_mem_kept", 1, o.data, 32'h1000_000F);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
